// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: iCE40 SPI register map, status bits, CR2 values and sequencer states
package dac_spi_pkg;
  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_CSR  = 4'hF;
  localparam int SR_TRDY = 4;
  localparam int SR_TIP  = 7;
  localparam logic [7:0] CR1_SPE  = 8'h80;
  localparam logic [7:0] CSR_CS0  = 8'h01;
  localparam logic [7:0] CR2_HOLD = 8'hC0;
  localparam logic [7:0] CR2_REL  = 8'h80;
  typedef enum logic [3:0] {
    INIT_CR1, INIT_BR, INIT_CSR, INIT_CR2, IDLE, REJECT, CS_HOLD,
    POLL_TRDY, WRITE_TX, POLL_TIP, CS_REL, CS_ABORT, DONE
  } state_t;
endpackage

// File: rtl/dac_spi_sequencer_sb_master.sv
// sb_master: one SB access at a time with strobe/ack handshake; optional ack timeout (ACK_TIMEOUT_EN)
module sb_master #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       ack,
  input  logic [7:0] sb_rdata,
  output logic       stb,
  output logic       sb_wr,
  output logic [7:0] sb_addr,
  output logic [7:0] sb_wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       timeout
);
  logic expire;
`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] cnt;
  assign expire = stb && !ack && cnt == TW'(TIMEOUT_CYC - 1);
  // counts strobe cycles that have not yet been acknowledged
  always_ff @(posedge clk)
    cnt <= (rst || !stb || ack) ? '0 : cnt + 1'b1;
`else
  assign expire = 1'b0;
`endif
  // a new access starts only after the done/timeout cycle, guaranteeing an idle gap
  always_ff @(posedge clk) begin
    if (rst) begin
      stb      <= 1'b0;
      sb_wr    <= 1'b0;
      sb_addr  <= '0;
      sb_wdata <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      timeout  <= 1'b0;
    end else begin
      done    <= stb && ack;
      timeout <= expire;
      if (stb && ack) begin
        stb   <= 1'b0;
        rdata <= sb_rdata;
      end else if (expire) begin
        stb <= 1'b0;
      end else if (req && !stb && !done && !timeout) begin
        stb      <= 1'b1;
        sb_wr    <= wr;
        sb_addr  <= addr;
        sb_wdata <= wdata;
      end
    end
  end
endmodule

// File: rtl/dac_spi_sequencer.sv
// dac_spi_sequencer: DAC write sequencer over the iCE40 SPI system bus; ACK_TIMEOUT_EN enables SB ack timeout
module dac_spi_sequencer
  import dac_spi_pkg::*;
#(
  parameter int         DATA_W      = 12,
  parameter int         CHANNELS    = 4,
  parameter int         FRAME_BYTES = 3,
  parameter logic [3:0] CMD_WR      = 4'h3,
  parameter logic [3:0] SB_BASE     = 4'h0,
  parameter logic [7:0] SPI_BR      = 8'h01,
  parameter int         TIMEOUT_CYC = 63,
  localparam int        CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [DATA_W-1:0] i_Data,
  input  logic [CH_W-1:0]   i_Channel,
  input  logic              i_Valid,
  output logic              o_Ready,
  output logic              o_Done,
  output logic              o_Error,
  output logic [7:0]        o_SB_Addr,
  output logic              o_SB_Wr,
  output logic              o_SB_Stb,
  output logic [7:0]        o_SB_Dat,
  input  logic [7:0]        i_SB_Dat,
  input  logic              i_SB_Ack
);
  localparam int FW = 8 * FRAME_BYTES;
  localparam int IW = $clog2(FRAME_BYTES + 1);
  state_t state, nxt;
  logic req, wr, sb_done, sb_timeout, bad, trdy, tip;
  logic [7:0] addr, wdata, sb_rdata;
  logic [FW-1:0] frame, frame_init;
  logic [IW-1:0] idx;
  assign bad        = int'(i_Channel) >= CHANNELS;
  assign frame_init = (FW'({CMD_WR, 4'(i_Channel)}) << (FW - 8)) | (FW'(i_Data) << (FW - 8 - DATA_W));
  assign trdy       = |(sb_rdata & (8'h01 << SR_TRDY));
  assign tip        = |(sb_rdata & (8'h01 << SR_TIP));
  assign o_Ready    = state == IDLE;
  assign o_Done     = state == DONE;
  sb_master #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_sb (
    .clk(i_Clock), .rst(i_Reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(i_SB_Ack), .sb_rdata(i_SB_Dat), .stb(o_SB_Stb), .sb_wr(o_SB_Wr),
    .sb_addr(o_SB_Addr), .sb_wdata(o_SB_Dat), .done(sb_done), .rdata(sb_rdata),
    .timeout(sb_timeout)
  );
  // state register
  always_ff @(posedge i_Clock)
    state <= i_Reset ? INIT_CR1 : nxt;
  // one SB request per state; a timeout diverts to a single CS release attempt
  always_comb begin
    nxt   = state;
    req   = 1'b0;
    wr    = 1'b1;
    addr  = {SB_BASE, REG_CR2};
    wdata = CR2_REL;
    case (state)
      INIT_CR1: begin
        req = 1'b1; addr = {SB_BASE, REG_CR1}; wdata = CR1_SPE;
        if (sb_done) nxt = INIT_BR;
      end
      INIT_BR: begin
        req = 1'b1; addr = {SB_BASE, REG_BR}; wdata = SPI_BR;
        if (sb_done) nxt = INIT_CSR;
      end
      INIT_CSR: begin
        req = 1'b1; addr = {SB_BASE, REG_CSR}; wdata = CSR_CS0;
        if (sb_done) nxt = INIT_CR2;
      end
      INIT_CR2: begin
        req = 1'b1;
        if (sb_done) nxt = IDLE;
      end
      IDLE:     if (i_Valid) nxt = bad ? REJECT : CS_HOLD;
      REJECT:   nxt = IDLE;
      CS_HOLD: begin
        req = 1'b1; wdata = CR2_HOLD;
        if (sb_done) nxt = POLL_TRDY;
      end
      POLL_TRDY: begin
        req = 1'b1; wr = 1'b0; addr = {SB_BASE, REG_SR}; wdata = '0;
        if (sb_done && trdy) nxt = WRITE_TX;
      end
      WRITE_TX: begin
        req = 1'b1; addr = {SB_BASE, REG_TXDR}; wdata = frame[FW-1 -: 8];
        if (sb_done) nxt = (idx == IW'(FRAME_BYTES - 1)) ? POLL_TIP : POLL_TRDY;
      end
      POLL_TIP: begin
        req = 1'b1; wr = 1'b0; addr = {SB_BASE, REG_SR}; wdata = '0;
        if (sb_done && !tip && trdy) nxt = CS_REL;
      end
      CS_REL: begin
        req = 1'b1;
        if (sb_done) nxt = DONE;
      end
      CS_ABORT: begin
        req = 1'b1;
        if (sb_done || sb_timeout) nxt = IDLE;
      end
      DONE:     nxt = IDLE;
      default:  nxt = INIT_CR1;
    endcase
    if (sb_timeout && state != CS_ABORT) nxt = CS_ABORT;
  end
  // request latch, byte walker and sticky error
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      frame   <= '0;
      idx     <= '0;
      o_Error <= 1'b0;
    end else if (state == IDLE && i_Valid) begin
      frame   <= frame_init;
      idx     <= '0;
      o_Error <= bad;
    end else begin
      if (sb_timeout) o_Error <= 1'b1;
      if (state == WRITE_TX && sb_done) begin
        idx   <= idx + 1'b1;
        frame <= frame << 8;
      end
    end
  end
endmodule
